// File: rtl/dbg_loader_if.sv
// Debug loader bus bundle: serial rx/tx byte streams, RAM debug port, halt line and PC tap.
interface dbg_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mem_rdata_dbg;
  logic [31:0] pc;
  logic        debug;
  logic [31:0] mem_addr_dbg;
  logic [31:0] mem_wdata_dbg;
  logic [1:0]  mem_byte_sel_dbg;
  logic        mem_we_dbg;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_rdata_dbg, pc,
    output rx_ready, tx_data, tx_valid, debug,
           mem_addr_dbg, mem_wdata_dbg, mem_byte_sel_dbg, mem_we_dbg
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_rdata_dbg, pc,
    input  rx_ready, tx_data, tx_valid, debug,
           mem_addr_dbg, mem_wdata_dbg, mem_byte_sel_dbg, mem_we_dbg
  );
endinterface

// File: rtl/dbg_loader.sv
// Host debug front end: decodes serial byte commands (H/G/W/R/P) into halt control,
// single-cycle debug-port RAM accesses and a byte response stream.
module dbg_loader #(
  parameter logic [1:0]  WORD_SEL = 2'b10,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  dbg_loader_if.master bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_CNT, S_WDATA, S_WRITE, S_ACK, S_RD_REQ, S_RD_WAIT, S_TX
  } state_t;

  state_t            state;
  logic [1:0]        bcnt;
  logic [1:0]        wcnt;
  logic [CNT_W-1:0]  word_cnt;
  logic [31:0]       shreg;
  logic              is_write;
  logic              is_pc;

  logic              rx_fire;
  logic              tx_fire;
  logic              rd_done;
  logic [CNT_W-1:0]  cnt_full;

  assign rx_fire  = bus.rx_valid & bus.rx_ready;
  assign tx_fire  = bus.tx_valid & bus.tx_ready;
  assign cnt_full = {bus.rx_data, word_cnt[15:8]};
  assign bus.mem_byte_sel_dbg = WORD_SEL;

  // Read data is valid RD_LAT cycles after the address was first presented in RD_REQ.
  assign rd_done = ((state == S_RD_REQ)  && (RD_LAT == 0)) ||
                   ((state == S_RD_WAIT) && (wcnt == 2'(RD_LAT - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      bcnt              <= '0;
      wcnt              <= '0;
      word_cnt          <= '0;
      shreg             <= '0;
      is_write          <= 1'b0;
      is_pc             <= 1'b0;
      bus.rx_ready      <= 1'b1;
      bus.tx_data       <= '0;
      bus.tx_valid      <= 1'b0;
      bus.debug         <= 1'b1;
      bus.mem_addr_dbg  <= '0;
      bus.mem_wdata_dbg <= '0;
      bus.mem_we_dbg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            case (bus.rx_data)
              8'h48: bus.debug <= 1'b1;
              8'h47: bus.debug <= 1'b0;
              8'h57, 8'h52: begin
                bus.debug <= 1'b1;
                is_write  <= (bus.rx_data == 8'h57);
                is_pc     <= 1'b0;
                bcnt      <= '0;
                state     <= S_ADDR;
              end
              8'h50: begin
                shreg        <= bus.pc;
                bus.tx_data  <= bus.pc[7:0];
                bus.tx_valid <= 1'b1;
                bus.rx_ready <= 1'b0;
                is_pc        <= 1'b1;
                bcnt         <= '0;
                state        <= S_TX;
              end
              default: ;
            endcase
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            bus.mem_addr_dbg <= {bus.rx_data, bus.mem_addr_dbg[31:8]};
            bcnt             <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= S_CNT;
          end
        end

        S_CNT: begin
          if (rx_fire) begin
            word_cnt <= cnt_full;
            bcnt     <= bcnt + 2'd1;
            if (bcnt == 2'd1) begin
              bcnt <= '0;
              if (cnt_full == '0) begin
                if (is_write) begin
                  bus.tx_data  <= ACK_BYTE;
                  bus.tx_valid <= 1'b1;
                  bus.rx_ready <= 1'b0;
                  state        <= S_ACK;
                end else begin
                  state <= S_IDLE;
                end
              end else if (is_write) begin
                state <= S_WDATA;
              end else begin
                bus.rx_ready <= 1'b0;
                state        <= S_RD_REQ;
              end
            end
          end
        end

        S_WDATA: begin
          if (rx_fire) begin
            bus.mem_wdata_dbg <= {bus.rx_data, bus.mem_wdata_dbg[31:8]};
            bcnt              <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              bus.mem_we_dbg <= 1'b1;
              bus.rx_ready   <= 1'b0;
              state          <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          bus.mem_we_dbg   <= 1'b0;
          bus.mem_addr_dbg <= bus.mem_addr_dbg + 32'd4;
          word_cnt         <= word_cnt - 16'd1;
          if (word_cnt == 16'd1) begin
            bus.tx_data  <= ACK_BYTE;
            bus.tx_valid <= 1'b1;
            state        <= S_ACK;
          end else begin
            bus.rx_ready <= 1'b1;
            state        <= S_WDATA;
          end
        end

        S_ACK: begin
          if (tx_fire) begin
            bus.tx_valid <= 1'b0;
            bus.rx_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end

        S_RD_REQ, S_RD_WAIT: begin
          if (rd_done) begin
            shreg        <= bus.mem_rdata_dbg;
            bus.tx_data  <= bus.mem_rdata_dbg[7:0];
            bus.tx_valid <= 1'b1;
            bcnt         <= '0;
            state        <= S_TX;
          end else if (state == S_RD_REQ) begin
            wcnt  <= '0;
            state <= S_RD_WAIT;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end

        S_TX: begin
          if (tx_fire) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= shreg >> 8;
            if (bcnt == 2'd3) begin
              bus.tx_valid <= 1'b0;
              if (is_pc) begin
                is_pc        <= 1'b0;
                bus.rx_ready <= 1'b1;
                state        <= S_IDLE;
              end else begin
                bus.mem_addr_dbg <= bus.mem_addr_dbg + 32'd4;
                word_cnt         <= word_cnt - 16'd1;
                if (word_cnt == 16'd1) begin
                  bus.rx_ready <= 1'b1;
                  state        <= S_IDLE;
                end else begin
                  state <= S_RD_REQ;
                end
              end
            end else begin
              bus.tx_data <= shreg[15:8];
            end
          end
        end

        default: begin
          bus.rx_ready <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_loader.sv
// Bench for dbg_loader: command-level reference model with queued write/tx expectations,
// a one-cycle-latency RAM responder, and a stalling transmitter.
module tb_dbg_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dbg_loader_if ifc();

  dbg_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  wr_t         exp_wr[$];
  wr_t         wr_log[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic        exp_debug = 1'b1;
  int          stall_cycles = 0;
  int          stall_seen = 0;

  // RAM behind the debug port: registered read, one cycle of latency.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (ifc.mem_we_dbg) ram[ifc.mem_addr_dbg[9:2]] <= ifc.mem_wdata_dbg;
    ifc.mem_rdata_dbg <= ram[ifc.mem_addr_dbg[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transmitter: holds tx_ready low for stall_cycles cycles before taking each byte.
  initial begin
    int scnt;
    scnt = 0;
    ifc.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!ifc.tx_valid) begin
        ifc.tx_ready = 1'b0;
        scnt = 0;
      end else if (scnt < stall_cycles) begin
        ifc.tx_ready = 1'b0;
        scnt++;
      end else begin
        ifc.tx_ready = 1'b1;
        scnt = 0;
      end
    end
  end

  // Per-cycle compare against the queued expectations.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    wr_t        w;
    logic [7:0] b;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("debug_level", 32'(ifc.debug), 32'(exp_debug));
        if (ifc.mem_we_dbg) begin
          wr_log.push_back('{addr: ifc.mem_addr_dbg, data: ifc.mem_wdata_dbg});
          if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                     ifc.mem_addr_dbg, ifc.mem_wdata_dbg);
          end else begin
            w = exp_wr.pop_front();
            chk("write_addr", ifc.mem_addr_dbg, w.addr);
            chk("write_data", ifc.mem_wdata_dbg, w.data);
            chk("write_bytesel", 32'(ifc.mem_byte_sel_dbg), 32'h2);
          end
        end
        if (prev_stall) begin
          stall_seen++;
          chk("tx_valid_hold", 32'(ifc.tx_valid), 32'h1);
          chk("tx_data_hold", 32'(ifc.tx_data), 32'(prev_data));
        end
        if (ifc.tx_valid && ifc.tx_ready) begin
          tx_log.push_back(ifc.tx_data);
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_tx: got %h, expected no byte", ifc.tx_data);
          end else begin
            b = exp_tx.pop_front();
            chk("tx_byte", 32'(ifc.tx_data), 32'(b));
          end
        end
        prev_stall = ifc.tx_valid && !ifc.tx_ready;
        prev_data  = ifc.tx_data;
      end
    end
  end

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ifc.rx_ready && t < 2000);
    chk("rx_accept", 32'(ifc.rx_ready), 32'h1);
    @(posedge clk);
    #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] addr, input logic [15:0] n);
    send_byte(c);
    exp_debug = 1'b1;
    send_word(addr);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic cmd_write(input logic [31:0] addr, input logic [31:0] words[$]);
    for (int i = 0; i < words.size(); i++) begin
      exp_wr.push_back('{addr: addr + 32'(4 * i), data: words[i]});
      ref_mem[addr + 32'(4 * i)] = words[i];
    end
    exp_tx.push_back(8'hAA);
    send_cmd(8'h57, addr, 16'(words.size()));
    for (int i = 0; i < words.size(); i++) send_word(words[i]);
  endtask

  task automatic cmd_read(input logic [31:0] addr, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = ref_mem[addr + 32'(4 * i)];
      for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
    end
    send_cmd(8'h52, addr, 16'(n));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || ifc.tx_valid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", 32'(t < 5000), 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wl[$];
    logic [7:0]  pbytes[$];

    ifc.rx_valid = 1'b0;
    ifc.rx_data  = '0;
    ifc.pc       = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_debug", 32'(ifc.debug), 32'h1);
    chk("rst_rx_ready", 32'(ifc.rx_ready), 32'h1);
    chk("rst_tx_valid", 32'(ifc.tx_valid), 32'h0);
    chk("rst_tx_data", 32'(ifc.tx_data), 32'h0);
    chk("rst_addr", ifc.mem_addr_dbg, 32'h0);
    chk("rst_wdata", ifc.mem_wdata_dbg, 32'h0);
    chk("rst_we", 32'(ifc.mem_we_dbg), 32'h0);
    @(posedge clk);
    #1;

    // 'G' releases the CPU
    send_byte(8'h47);
    exp_debug = 1'b0;
    @(negedge clk);
    chk("g_debug", 32'(ifc.debug), 32'h0);
    @(posedge clk);
    #1;

    // Two-word write at 0x100
    tx_log.delete();
    wr_log.delete();
    wl.delete();
    wl.push_back(32'h11223344);
    wl.push_back(32'hDEADBEEF);
    cmd_write(32'h0000_0100, wl);
    drain();
    chk("w1_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("w1_addr0", wr_log[0].addr, 32'h100);
      chk("w1_data0", wr_log[0].data, 32'h11223344);
      chk("w1_addr1", wr_log[1].addr, 32'h104);
      chk("w1_data1", wr_log[1].data, 32'hDEADBEEF);
    end
    chk("w1_ack_n", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("w1_ack", 32'(tx_log[0]), 32'hAA);

    // Two-word read back from 0x100
    tx_log.delete();
    cmd_read(32'h0000_0100, 2);
    drain();
    pbytes.delete();
    pbytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk("r1_n", 32'(tx_log.size()), 32'd8);
    if (tx_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("r1_byte", 32'(tx_log[i]), 32'(pbytes[i]));

    // Address wrap across 2^32
    wr_log.delete();
    wl.delete();
    wl.push_back(32'hCAFEF00D);
    wl.push_back(32'h0BADC0DE);
    cmd_write(32'hFFFF_FFFC, wl);
    drain();
    chk("wrap_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("wrap_addr0", wr_log[0].addr, 32'hFFFF_FFFC);
      chk("wrap_addr1", wr_log[1].addr, 32'h0000_0000);
    end

    // Zero-length read sends nothing
    tx_log.delete();
    cmd_read(32'h0000_0200, 0);
    @(negedge clk);
    chk("r0_rx_ready", 32'(ifc.rx_ready), 32'h1);
    chk("r0_tx_valid", 32'(ifc.tx_valid), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("r0_no_tx", 32'(tx_log.size()), 32'd0);

    // 'P' with a stalling transmitter
    tx_log.delete();
    ifc.pc = 32'h0000_0A0C;
    stall_cycles = 5;
    stall_seen = 0;
    for (int k = 0; k < 4; k++) exp_tx.push_back(ifc.pc[8*k +: 8]);
    send_byte(8'h50);
    drain();
    stall_cycles = 0;
    pbytes = '{8'h0C, 8'h0A, 8'h00, 8'h00};
    chk("p_n", 32'(tx_log.size()), 32'd4);
    if (tx_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("p_byte", 32'(tx_log[i]), 32'(pbytes[i]));
    chk("p_stalls", 32'(stall_seen >= 20), 32'h1);

    // Reset in the middle of a write data word
    wr_log.delete();
    send_cmd(8'h57, 32'h0000_0010, 16'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_debug = 1'b1;
    @(negedge clk);
    chk("mid_rst_addr", ifc.mem_addr_dbg, 32'h0);
    chk("mid_rst_wdata", ifc.mem_wdata_dbg, 32'h0);
    chk("mid_rst_rx_ready", 32'(ifc.rx_ready), 32'h1);
    @(posedge clk);
    #1;
    send_byte(8'h99);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_write", 32'(wr_log.size()), 32'd0);
    send_byte(8'h47);
    exp_debug = 1'b0;
    @(negedge clk);
    chk("post_rst_g", 32'(ifc.debug), 32'h0);
    @(posedge clk);
    #1;
    send_byte(8'h48);
    exp_debug = 1'b1;
    @(negedge clk);
    chk("post_rst_h", 32'(ifc.debug), 32'h1);
    repeat (3) @(posedge clk);
    #1;

    chk("left_tx", 32'(exp_tx.size()), 32'd0);
    chk("left_wr", 32'(exp_wr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
